// File: rtl/vga_scan_out_pkg.sv
// Shared constants for the 800x600@72 Hz raster: default timing, derived totals,
// pixel-code bit positions and the play-field window expressed in scan coordinates.
package vga_scan_out_pkg;

    localparam int unsigned VGA_H_VISIBLE = 800;
    localparam int unsigned VGA_H_FRONT   = 56;
    localparam int unsigned VGA_H_SYNC    = 120;
    localparam int unsigned VGA_H_BACK    = 64;

    localparam int unsigned VGA_V_VISIBLE = 600;
    localparam int unsigned VGA_V_FRONT   = 37;
    localparam int unsigned VGA_V_SYNC    = 6;
    localparam int unsigned VGA_V_BACK    = 23;

    localparam int unsigned H_TOTAL = VGA_H_VISIBLE + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;
    localparam int unsigned V_TOTAL = VGA_V_VISIBLE + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;

    localparam int H_CNT_W = 12;
    localparam int V_CNT_W = 11;

    localparam int PIX_EN = 3;
    localparam int PIX_R  = 2;
    localparam int PIX_G  = 1;
    localparam int PIX_B  = 0;

    // Play-field window used by the draw_* blocks, in hcounter/vcounter units.
    localparam int unsigned LEFT = 16;
    localparam int unsigned TOP  = 16;
    localparam int unsigned MAXX = 784;
    localparam int unsigned MAXY = 584;

    function automatic logic [3:0] pix_level(input logic on);
        return on ? 4'hF : 4'h0;
    endfunction

endpackage

// File: rtl/vga_scan_out_scan_counter.sv
// Horizontal/vertical position pair; vcount steps on the hcount wrap.
// Totals are parameters so a lower-resolution mode can reuse this block.
module scan_counter
    import vga_scan_out_pkg::*;
#(
    parameter int unsigned H_TOT = H_TOTAL,
    parameter int unsigned V_TOT = V_TOTAL,
    parameter int          H_W   = H_CNT_W,
    parameter int          V_W   = V_CNT_W
) (
    input  logic           clk,
    input  logic           rst_n,
    output logic [H_W-1:0] hcount,
    output logic [V_W-1:0] vcount,
    output logic           frame_last
);

    localparam logic [H_W-1:0] H_LAST = H_W'(H_TOT - 1);
    localparam logic [V_W-1:0] V_LAST = V_W'(V_TOT - 1);
    localparam logic [H_W-1:0] H_ONE  = H_W'(1);
    localparam logic [V_W-1:0] V_ONE  = V_W'(1);

    logic [H_W-1:0] hcount_q, hcount_d;
    logic [V_W-1:0] vcount_q, vcount_d;
    logic           h_last, v_last;

    always_comb begin
        h_last   = (hcount_q == H_LAST);
        v_last   = (vcount_q == V_LAST);
        hcount_d = h_last ? '0 : hcount_q + H_ONE;
        vcount_d = vcount_q;
        if (h_last) begin
            vcount_d = v_last ? '0 : vcount_q + V_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcount_q <= '0;
            vcount_q <= '0;
        end else begin
            hcount_q <= hcount_d;
            vcount_q <= vcount_d;
        end
    end

    assign hcount     = hcount_q;
    assign vcount     = vcount_q;
    assign frame_last = h_last && v_last;

endmodule

// File: rtl/vga_scan_out.sv
// Raster timing for the draw_* blocks plus the one-clock output pipeline that
// turns their pixel code into DAC levels with syncs and blank aligned to it.
module vga_scan_out
    import vga_scan_out_pkg::*;
#(
    parameter int unsigned H_VISIBLE = VGA_H_VISIBLE,
    parameter int unsigned H_FRONT   = VGA_H_FRONT,
    parameter int unsigned H_SYNC    = VGA_H_SYNC,
    parameter int unsigned H_BACK    = VGA_H_BACK,
    parameter int unsigned V_VISIBLE = VGA_V_VISIBLE,
    parameter int unsigned V_FRONT   = VGA_V_FRONT,
    parameter int unsigned V_SYNC    = VGA_V_SYNC,
    parameter int unsigned V_BACK    = VGA_V_BACK,
    parameter logic        SYNC_POL  = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    output logic [H_CNT_W-1:0]   hcounter,
    output logic [V_CNT_W-1:0]   vcounter,
    input  logic [3:0]           pix_in,
    output logic [3:0]           vga_r,
    output logic [3:0]           vga_g,
    output logic [3:0]           vga_b,
    output logic                 vga_hs,
    output logic                 vga_vs,
    output logic                 vga_blank_n,
    output logic                 frame_tick
);

    localparam int unsigned H_SUM = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_SUM = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [H_CNT_W-1:0] H_ACT_END = H_CNT_W'(H_VISIBLE);
    localparam logic [H_CNT_W-1:0] HS_BEGIN  = H_CNT_W'(H_VISIBLE + H_FRONT);
    localparam logic [H_CNT_W-1:0] HS_END    = H_CNT_W'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [V_CNT_W-1:0] V_ACT_END = V_CNT_W'(V_VISIBLE);
    localparam logic [V_CNT_W-1:0] VS_BEGIN  = V_CNT_W'(V_VISIBLE + V_FRONT);
    localparam logic [V_CNT_W-1:0] VS_END    = V_CNT_W'(V_VISIBLE + V_FRONT + V_SYNC);

    logic frame_last;

    scan_counter #(
        .H_TOT (H_SUM),
        .V_TOT (V_SUM),
        .H_W   (H_CNT_W),
        .V_W   (V_CNT_W)
    ) u_scan (
        .clk        (clk),
        .rst_n      (rst_n),
        .hcount     (hcounter),
        .vcount     (vcounter),
        .frame_last (frame_last)
    );

    logic active, hs_raw, vs_raw;

    always_comb begin
        active = (hcounter < H_ACT_END) && (vcounter < V_ACT_END);
        hs_raw = (hcounter >= HS_BEGIN) && (hcounter < HS_END);
        vs_raw = (vcounter >= VS_BEGIN) && (vcounter < VS_END);
    end

    logic [3:0] vga_r_q, vga_r_d;
    logic [3:0] vga_g_q, vga_g_d;
    logic [3:0] vga_b_q, vga_b_d;
    logic       vga_hs_q, vga_hs_d;
    logic       vga_vs_q, vga_vs_d;
    logic       blank_n_q, blank_n_d;
    logic       wrap_q, wrap_d;
    logic       frame_tick_q, frame_tick_d;

    // wrap_q marks the cycle the counters show (0,0) after a wrap, so the
    // release from reset (also at (0,0)) never produces a tick.
    always_comb begin
        vga_r_d      = pix_level(active && pix_in[PIX_EN] && pix_in[PIX_R]);
        vga_g_d      = pix_level(active && pix_in[PIX_EN] && pix_in[PIX_G]);
        vga_b_d      = pix_level(active && pix_in[PIX_EN] && pix_in[PIX_B]);
        vga_hs_d     = hs_raw ^ ~SYNC_POL;
        vga_vs_d     = vs_raw ^ ~SYNC_POL;
        blank_n_d    = active;
        wrap_d       = frame_last;
        frame_tick_d = wrap_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vga_r_q      <= 4'h0;
            vga_g_q      <= 4'h0;
            vga_b_q      <= 4'h0;
            vga_hs_q     <= ~SYNC_POL;
            vga_vs_q     <= ~SYNC_POL;
            blank_n_q    <= 1'b0;
            wrap_q       <= 1'b0;
            frame_tick_q <= 1'b0;
        end else begin
            vga_r_q      <= vga_r_d;
            vga_g_q      <= vga_g_d;
            vga_b_q      <= vga_b_d;
            vga_hs_q     <= vga_hs_d;
            vga_vs_q     <= vga_vs_d;
            blank_n_q    <= blank_n_d;
            wrap_q       <= wrap_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign vga_r       = vga_r_q;
    assign vga_g       = vga_g_q;
    assign vga_b       = vga_b_q;
    assign vga_hs      = vga_hs_q;
    assign vga_vs      = vga_vs_q;
    assign vga_blank_n = blank_n_q;
    assign frame_tick  = frame_tick_q;

endmodule

// File: tb/tb_vga_scan_out.sv
// Bench for vga_scan_out: full-size instance for reset, line timing and pixel
// vectors; a shrunken instance (inverted sync polarity) for whole-frame checks.
module tb_vga_scan_out;

    localparam int HT_A = 1040;

    localparam int HV_B = 16, HF_B = 4, HS_B = 6, HB_B = 4;
    localparam int VV_B = 10, VF_B = 2, VS_B = 3, VB_B = 2;
    localparam int HT_B = HV_B + HF_B + HS_B + HB_B;
    localparam int VT_B = VV_B + VF_B + VS_B + VB_B;
    localparam int F_B  = HT_B * VT_B;
    localparam logic POL_B = 1'b0;

    typedef struct packed {
        logic [11:0] h;
        logic [10:0] v;
        logic [3:0]  r;
        logic [3:0]  g;
        logic [3:0]  b;
        logic        hs;
        logic        vs;
        logic        blank;
        logic        tick;
    } obs_t;

    typedef struct {
        int         h;
        int         v;
        logic [3:0] pix;
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
        logic       blank;
        logic       hs;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_a_n, rst_b_n;
    logic [3:0]  pix_a, pix_b;
    logic [11:0] hcounter_a, hcounter_b;
    logic [10:0] vcounter_a, vcounter_b;
    logic [3:0]  r_a, g_a, b_a, r_b, g_b, b_b;
    logic        hs_a, vs_a, blank_a, tick_a;
    logic        hs_b, vs_b, blank_b, tick_b;

    int n_cmp = 0;
    int n_bad = 0;
    int nb = 0;
    logic [3:0] pix_last = 4'h0;
    int tick_q[$];
    vec_t vt[9];

    always #5 clk = ~clk;

    vga_scan_out dut_a (
        .clk(clk), .rst_n(rst_a_n), .hcounter(hcounter_a), .vcounter(vcounter_a),
        .pix_in(pix_a), .vga_r(r_a), .vga_g(g_a), .vga_b(b_a), .vga_hs(hs_a),
        .vga_vs(vs_a), .vga_blank_n(blank_a), .frame_tick(tick_a)
    );

    vga_scan_out #(
        .H_VISIBLE(HV_B), .H_FRONT(HF_B), .H_SYNC(HS_B), .H_BACK(HB_B),
        .V_VISIBLE(VV_B), .V_FRONT(VF_B), .V_SYNC(VS_B), .V_BACK(VB_B),
        .SYNC_POL(POL_B)
    ) dut_b (
        .clk(clk), .rst_n(rst_b_n), .hcounter(hcounter_b), .vcounter(vcounter_b),
        .pix_in(pix_b), .vga_r(r_b), .vga_g(g_b), .vga_b(b_b), .vga_hs(hs_b),
        .vga_vs(vs_b), .vga_blank_n(blank_b), .frame_tick(tick_b)
    );

    function automatic string fmt(input obs_t o);
        return $sformatf("h=%0d v=%0d r=%h g=%h b=%h hs=%b vs=%b blank=%b tick=%b",
                         o.h, o.v, o.r, o.g, o.b, o.hs, o.vs, o.blank, o.tick);
    endfunction

    function automatic obs_t get_a();
        obs_t o;
        o.h = hcounter_a; o.v = vcounter_a; o.r = r_a; o.g = g_a; o.b = b_a;
        o.hs = hs_a; o.vs = vs_a; o.blank = blank_a; o.tick = tick_a;
        return o;
    endfunction

    function automatic obs_t get_b();
        obs_t o;
        o.h = hcounter_b; o.v = vcounter_b; o.r = r_b; o.g = g_b; o.b = b_b;
        o.hs = hs_b; o.vs = vs_b; o.blank = blank_b; o.tick = tick_b;
        return o;
    endfunction

    function automatic obs_t rst_val(input logic pol);
        obs_t o;
        o = '0;
        o.hs = ~pol;
        o.vs = ~pol;
        return o;
    endfunction

    // Reference for the small instance: n = clock edges since reset release,
    // p = pixel code that was on pix_in when edge n happened.
    function automatic obs_t exp_b(input int n, input logic [3:0] p);
        obs_t e;
        int hp, vp;
        logic act;
        e = rst_val(POL_B);
        e.h = 12'(n % HT_B);
        e.v = 11'((n / HT_B) % VT_B);
        if (n == 0) return e;
        hp  = (n - 1) % HT_B;
        vp  = ((n - 1) / HT_B) % VT_B;
        act = (hp < HV_B) && (vp < VV_B);
        e.r = (act && p[3] && p[2]) ? 4'hF : 4'h0;
        e.g = (act && p[3] && p[1]) ? 4'hF : 4'h0;
        e.b = (act && p[3] && p[0]) ? 4'hF : 4'h0;
        e.hs = (hp >= HV_B + HF_B && hp < HV_B + HF_B + HS_B) ? POL_B : ~POL_B;
        e.vs = (vp >= VV_B + VF_B && vp < VV_B + VF_B + VS_B) ? POL_B : ~POL_B;
        e.blank = act;
        e.tick = ((n - 1) > 0) && ((n - 1) % F_B == 0);
        return e;
    endfunction

    task automatic chk_obs(input string nm, input obs_t got, input obs_t exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %s, expected %s", nm, fmt(got), fmt(exp));
        end
    endtask

    task automatic chk_int(input string nm, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, got, exp);
        end
    endtask

    task automatic wait_a(input int h, input int v);
        int i;
        for (i = 0; i < 20000; i++) begin
            if (hcounter_a == 12'(h) && vcounter_a == 11'(v)) break;
            @(negedge clk);
        end
        if (i == 20000) begin
            n_cmp++;
            n_bad++;
            $display("FAIL wait_a: position (%0d,%0d) not reached, now at (%0d,%0d)",
                     h, v, hcounter_a, vcounter_a);
        end
    endtask

    task automatic step_b();
        obs_t g;
        g = get_b();
        chk_obs($sformatf("scan_b n=%0d", nb), g, exp_b(nb, pix_last));
        if (g.tick) tick_q.push_back(nb);
        pix_b = 4'($urandom_range(0, 15));
        pix_last = pix_b;
        @(negedge clk);
        nb++;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int first, cnt;
        vt[0] = '{10,   5, 4'b1011, 4'h0, 4'hF, 4'hF, 1'b1, 1'b0};
        vt[1] = '{10,   6, 4'b0111, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0};
        vt[2] = '{11,   6, 4'b1100, 4'hF, 4'h0, 4'h0, 1'b1, 1'b0};
        vt[3] = '{799,  6, 4'b1111, 4'hF, 4'hF, 4'hF, 1'b1, 1'b0};
        vt[4] = '{800,  6, 4'b1111, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0};
        vt[5] = '{900,  6, 4'b1111, 4'h0, 4'h0, 4'h0, 1'b0, 1'b1};
        vt[6] = '{1039, 6, 4'b1111, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0};
        vt[7] = '{0,    7, 4'b1110, 4'hF, 4'hF, 4'h0, 1'b1, 1'b0};
        vt[8] = '{5,    7, 4'b1000, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0};

        rst_a_n = 1'b0;
        rst_b_n = 1'b0;
        pix_a = 4'hF;
        pix_b = 4'hF;
        repeat (5) @(negedge clk);
        chk_obs("reset_a", get_a(), rst_val(1'b1));
        chk_obs("reset_b", get_b(), rst_val(POL_B));

        rst_a_n = 1'b1;
        pix_a = 4'h0;
        @(negedge clk);
        chk_int("release_h", int'(hcounter_a), 1);
        chk_int("release_v", int'(vcounter_a), 0);
        chk_int("release_tick", int'(tick_a), 0);

        wait_a(1039, 0);
        chk_int("pre_wrap_v", int'(vcounter_a), 0);
        @(negedge clk);
        chk_int("wrap_h", int'(hcounter_a), 0);
        chk_int("wrap_v", int'(vcounter_a), 1);

        first = -1;
        cnt = 0;
        for (int i = 0; i < HT_A; i++) begin
            if (hs_a) begin
                if (first < 0) first = int'(hcounter_a);
                cnt++;
            end
            @(negedge clk);
        end
        chk_int("hs_first_h", first, 857);
        chk_int("hs_width", cnt, 120);

        foreach (vt[i]) begin
            wait_a(vt[i].h, vt[i].v);
            pix_a = vt[i].pix;
            @(negedge clk);
            pix_a = 4'h0;
            chk_int($sformatf("vec%0d rgb_blank_hs", i),
                    int'({r_a, g_a, b_a, blank_a, hs_a}),
                    int'({vt[i].r, vt[i].g, vt[i].b, vt[i].blank, vt[i].hs}));
        end

        // Constant white across one line: RGB must follow blank, one clock late.
        wait_a(0, 8);
        pix_a = 4'hF;
        for (int k = 0; k <= HT_A; k++) begin
            logic bl;
            bl = (((k + HT_A - 1) % HT_A) < 800) && (k != 0);
            chk_int($sformatf("blank_line k=%0d", k),
                    int'({r_a, g_a, b_a, blank_a}),
                    int'({bl ? 12'hFFF : 12'h000, bl}));
            @(negedge clk);
        end
        pix_a = 4'h0;

        rst_b_n = 1'b1;
        nb = 0;
        repeat (3 * F_B + 5) step_b();
        chk_int("tick_count", tick_q.size(), 3);
        if (tick_q.size() >= 3) begin
            chk_int("tick_first", tick_q[0], F_B + 1);
            chk_int("tick_spacing1", tick_q[1] - tick_q[0], F_B);
            chk_int("tick_spacing2", tick_q[2] - tick_q[1], F_B);
        end

        while ((nb % F_B) != 8 * HT_B) step_b();
        rst_b_n = 1'b0;
        #1;
        chk_obs("async_reset_b", get_b(), rst_val(POL_B));
        @(negedge clk);
        chk_obs("reset_hold_b", get_b(), rst_val(POL_B));
        rst_b_n = 1'b1;
        nb = 0;
        tick_q.delete();
        repeat (F_B + 20) step_b();
        chk_int("post_reset_tick_count", tick_q.size(), 1);
        if (tick_q.size() >= 1) begin
            chk_int("post_reset_tick_at", tick_q[0], F_B + 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
